// File: rtl/cl_pairhmm_job_stream_feeder.sv
// Parses a packed PairHMM job from a 32-bit AXI-Stream and replays its sections to the worker's
// sectioned loading protocol, then issues a start handshake.
module cl_pairhmm_job_stream_feeder #(
    parameter int MAX_SEQUENCE_LENGTH = 2048,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [31:0]                s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [31:0]                m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [2:0]                 stream_type_o,
    output logic [2*LEN_WIDTH+31:0]    request_o,
    output logic                       start_o,
    input  logic                       worker_ready_i,
    output logic                       busy_o,
    output logic                       error_o
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_HDR1, ST_SEC_R, ST_SEC_Q, ST_SEC_I, ST_SEC_D, ST_SEC_C, ST_SEC_H,
        ST_START, ST_DRAIN
    } state_t;

    localparam logic [2:0] STORE_R = 3'd0;
    localparam logic [2:0] STORE_Q = 3'd1;
    localparam logic [2:0] STORE_I = 3'd2;
    localparam logic [2:0] STORE_D = 3'd3;
    localparam logic [2:0] STORE_C = 3'd4;
    localparam logic [2:0] STORE_H = 3'd5;
    localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH+1)'(MAX_SEQUENCE_LENGTH);

    state_t                      state_q;
    logic [2:0]                  stream_type_q;
    logic [2*LEN_WIDTH+31:0]     request_q;
    logic                        start_q;
    logic                        error_q;
    logic [LEN_WIDTH-2:0]        cnt_q;
    logic [LEN_WIDTH-2:0]        sec_last;
    logic [LEN_WIDTH-1:0]        read_len_m1;
    logic [LEN_WIDTH-1:0]        hap_len_m1;
    logic                        s_fire;
    logic                        in_section;
    logic                        len_bad;

    function automatic state_t next_sec(input state_t s);
        case (s)
            ST_SEC_R: next_sec = ST_SEC_Q;
            ST_SEC_Q: next_sec = ST_SEC_I;
            ST_SEC_I: next_sec = ST_SEC_D;
            ST_SEC_D: next_sec = ST_SEC_C;
            default:  next_sec = ST_SEC_H;
        endcase
    endfunction

    function automatic logic [2:0] sec_type(input state_t s);
        case (s)
            ST_SEC_Q: sec_type = STORE_Q;
            ST_SEC_I: sec_type = STORE_I;
            ST_SEC_D: sec_type = STORE_D;
            ST_SEC_C: sec_type = STORE_C;
            ST_SEC_H: sec_type = STORE_H;
            default:  sec_type = STORE_R;
        endcase
    endfunction

    assign read_len_m1 = request_q[2*LEN_WIDTH+31 -: LEN_WIDTH];
    assign hap_len_m1  = request_q[LEN_WIDTH+31 -: LEN_WIDTH];
    assign sec_last    = (state_q == ST_SEC_H) ? {1'b0, hap_len_m1[LEN_WIDTH-1:2]}
                                               : {1'b0, read_len_m1[LEN_WIDTH-1:2]};
    assign in_section  = (state_q >= ST_SEC_R) && (state_q <= ST_SEC_H);
    assign s_fire      = s_axis_tvalid && s_axis_tready;
    assign len_bad     = ({1'b0, s_axis_tdata[LEN_WIDTH-1:0]} >= MAX_LEN) ||
                         ({1'b0, s_axis_tdata[16 +: LEN_WIDTH]} >= MAX_LEN);

    // Section words pass straight through so the worker sees no added latency.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        if (in_section) begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
        end else if (state_q == ST_IDLE) begin
            s_axis_tready = worker_ready_i && !reset;
        end else if (state_q == ST_HDR1 || state_q == ST_DRAIN) begin
            s_axis_tready = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            stream_type_q <= STORE_R;
            request_q     <= '0;
            start_q       <= 1'b0;
            error_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (s_fire) begin
                    request_q[2*LEN_WIDTH+31 -: 2*LEN_WIDTH] <=
                        {s_axis_tdata[LEN_WIDTH-1:0], s_axis_tdata[16 +: LEN_WIDTH]};
                    // A W0 carrying tlast already ended its job, so there is nothing to drain.
                    if (len_bad || s_axis_tlast) begin
                        error_q <= 1'b1;
                        state_q <= s_axis_tlast ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_q <= ST_HDR1;
                    end
                end
                ST_HDR1: if (s_fire) begin
                    if (s_axis_tlast) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        request_q[31:0] <= s_axis_tdata;
                        cnt_q           <= '0;
                        stream_type_q   <= STORE_R;
                        state_q         <= ST_SEC_R;
                    end
                end
                ST_SEC_R, ST_SEC_Q, ST_SEC_I, ST_SEC_D, ST_SEC_C, ST_SEC_H: if (s_fire) begin
                    if (state_q == ST_SEC_H && cnt_q == sec_last) begin
                        cnt_q         <= '0;
                        stream_type_q <= STORE_R;
                        if (s_axis_tlast) begin
                            start_q <= 1'b1;
                            state_q <= ST_START;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= ST_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        cnt_q         <= '0;
                        error_q       <= 1'b1;
                        stream_type_q <= STORE_R;
                        state_q       <= ST_IDLE;
                    end else if (cnt_q == sec_last) begin
                        cnt_q         <= '0;
                        stream_type_q <= sec_type(next_sec(state_q));
                        state_q       <= next_sec(state_q);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_START: if (!worker_ready_i) begin
                    start_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_DRAIN: if (s_fire && s_axis_tlast) begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stream_type_o = stream_type_q;
    assign request_o     = request_q;
    assign start_o       = start_q;
    assign error_o       = error_q;
    assign busy_o        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_cl_pairhmm_job_stream_feeder.sv
// Randomised job-stream bench: a job-level model predicts worker beats, request, start and error.
module tb_cl_pairhmm_job_stream_feeder;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [2:0]  stream_type_o;
    logic [63:0] request_o;
    logic        start_o;
    logic        worker_ready_i;
    logic        busy_o;
    logic        error_o;

    cl_pairhmm_job_stream_feeder #(.MAX_SEQUENCE_LENGTH(2048), .LEN_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .stream_type_o(stream_type_o),
        .request_o(request_o), .start_o(start_o), .worker_ready_i(worker_ready_i),
        .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] stim_q[$];   // {tlast, data}
    logic [34:0] exp_q[$];    // {stream type, data}
    int          start_count = 0;
    int          exp_starts = 0;
    bit          start_prev = 1'b0;
    bit          toggle_en = 1'b0;
    bit          exp_err = 1'b0;
    bit          job_err;
    logic [63:0] exp_req;
    int          job_len;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Worker-side monitor: every beat the worker takes must be the next predicted one.
    always @(negedge clock) begin
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
            end else begin
                logic [34:0] e;
                e = exp_q.pop_front();
                check("beat_data", 64'(m_axis_tdata), 64'(e[31:0]));
                check("beat_type", 64'(stream_type_o), 64'(e[34:32]));
            end
        end
        if (!reset && start_o && !start_prev) start_count++;
        start_prev = start_o;
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            m_axis_tready = toggle_en ? ~m_axis_tready : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Job model: word i of the body goes to section min(i/RW, 5); words after the last H word are dropped.
    task automatic build_job(input int rm1, input int hm1, input logic [31:0] init, input int last_idx);
        int rw, hw, total, n, lidx;
        bit bad;
        logic [31:0] d;
        rw    = (rm1 >> 2) + 1;
        hw    = (hm1 >> 2) + 1;
        total = 2 + 5 * rw + hw;
        bad   = (rm1 >= 2048) || (hm1 >= 2048);
        lidx  = (last_idx < 0) ? total - 1 : last_idx;
        n     = lidx + 1;
        stim_q.delete();
        for (int i = 0; i < n; i++) begin
            if (i == 0)      d = {16'(hm1), 16'(rm1)};
            else if (i == 1) d = init;
            else             d = $urandom;
            stim_q.push_back({(i == lidx), d});
            if (!bad && i >= 2 && i < total) begin
                int k, sec;
                k   = i - 2;
                sec = (k / rw < 5) ? k / rw : 5;
                exp_q.push_back({3'(sec), d});
            end
        end
        job_err = bad || (lidx != total - 1);
        exp_err = exp_err || job_err;
        if (!job_err) exp_starts++;
        exp_req = {16'(rm1), 16'(hm1), init};
        job_len = n;
    endtask

    task automatic drive_n(input int n);
        for (int i = 0; i < n; i++) begin
            logic [32:0] w;
            int t;
            w = stim_q.pop_front();
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                tick();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = w[31:0];
            s_axis_tlast  = w[32];
            t = 0;
            forever begin
                @(negedge clock);
                if (s_axis_tready) break;
                t++;
                if (t > 200) break;
            end
            if (t > 200) begin
                check("accept_timeout", 64'(s_axis_tready), 64'd1);
                break;
            end
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        if (!job_err) begin
            int t;
            t = 0;
            while (!start_o && t < 100) begin
                @(negedge clock);
                t++;
            end
            check({tag, "_start"}, 64'(start_o), 64'd1);
            check({tag, "_request"}, request_o, exp_req);
            check({tag, "_busy_start"}, 64'(busy_o), 64'd1);
            tick();
            worker_ready_i = 1'b0;
            tick();
            worker_ready_i = 1'b1;
            @(negedge clock);
            check({tag, "_start_drop"}, 64'(start_o), 64'd0);
            check({tag, "_request_held"}, request_o, exp_req);
            tick();
        end else begin
            repeat (4) tick();
        end
        @(negedge clock);
        check({tag, "_busy_after"}, 64'(busy_o), 64'd0);
        check({tag, "_error"}, 64'(error_o), 64'(exp_err));
        check({tag, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_start_count"}, 64'(start_count), 64'(exp_starts));
        $display("job %s done: checks=%0d errors=%0d", tag, checks, errors);
        tick();
    endtask

    initial begin
        int rw;
        reset = 1'b1; worker_ready_i = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        repeat (3) tick();
        @(negedge clock);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_mdata", 64'(m_axis_tdata), 64'd0);
        check("rst_type", 64'(stream_type_o), 64'd0);
        check("rst_request", request_o, 64'd0);
        check("rst_start", 64'(start_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        build_job(5, 7, 32'h7c4ffff6, -1);
        drive_n(job_len); finish_job("basic");

        toggle_en = 1'b1;
        build_job(5, 7, 32'h7c4ffff6, -1);
        drive_n(job_len); finish_job("toggle");
        toggle_en = 1'b0;

        for (int j = 0; j < 4; j++) begin
            toggle_en = $urandom_range(0, 1) == 1;
            build_job($urandom_range(0, 40), $urandom_range(0, 40), $urandom, -1);
            drive_n(job_len); finish_job("random");
        end
        toggle_en = 1'b0;

        rw = (11 >> 2) + 1;
        build_job(11, $urandom_range(0, 30), $urandom, 2 + rw + 2);
        drive_n(job_len); finish_job("early_tlast");
        build_job($urandom_range(0, 20), $urandom_range(0, 20), $urandom, -1);
        drive_n(job_len); finish_job("after_error");

        build_job(2048, 3, $urandom, 4);
        drive_n(job_len); finish_job("too_long");

        build_job(3, 3, $urandom, 2 + 5 + 1 + 2);
        drive_n(job_len); finish_job("missing_tlast");

        build_job($urandom_range(0, 20), $urandom_range(0, 20), $urandom, -1);
        worker_ready_i = 1'b0;
        s_axis_tvalid  = 1'b1;
        s_axis_tdata   = stim_q[0][31:0];
        repeat (4) begin
            @(negedge clock);
            check("wready_low_tready", 64'(s_axis_tready), 64'd0);
            check("wready_low_busy", 64'(busy_o), 64'd0);
        end
        tick();
        worker_ready_i = 1'b1;
        drive_n(job_len); finish_job("worker_wait");

        rw = (17 >> 2) + 1;
        build_job(17, 9, $urandom, -1);
        drive_n(2 + 3 * rw + 1);
        reset = 1'b1;
        tick();
        @(negedge clock);
        check("midrst_tready", 64'(s_axis_tready), 64'd0);
        check("midrst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst_mdata", 64'(m_axis_tdata), 64'd0);
        check("midrst_type", 64'(stream_type_o), 64'd0);
        check("midrst_request", request_o, 64'd0);
        check("midrst_start", 64'(start_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_error", 64'(error_o), 64'd0);
        exp_q.delete();
        stim_q.delete();
        exp_err = 1'b0;
        exp_starts--;
        tick();
        reset = 1'b0;
        tick();
        build_job($urandom_range(0, 30), $urandom_range(0, 30), $urandom, -1);
        drive_n(job_len); finish_job("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
